dac_feeder: RTL and testbench

- Transmit-side counterpart of the ADC capture path.
- Accepts 14-bit samples from system logic in the sys_CLK domain through a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample every DIV clocks to the DAC data bus, with a one-cycle write strobe.
- Applies the same two's/offset data inversion convention as the ADC path, so a captured sample looped back is reproduced unchanged.

---
 rtl/dac_feeder.sv | 126 ++++++++++++
 tb/tb_dac_feeder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dac_feeder.sv
// DAC transmit feeder: buffers samples from system logic in a small FIFO and
// releases one sample every DIV clocks to the DAC bus with a write strobe.
module dac_feeder #(
    parameter int WIDTH  = 14,
    parameter int DEPTH  = 8,
    parameter int DIV    = 4,
    parameter int INVERT = 1
) (
    input  logic                     sys_CLK,
    input  logic                     sys_RSTn,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         Din,
    input  logic                     Din_valid,
    output logic                     Din_ready,
    output logic [WIDTH-1:0]         Dout,
    output logic                     dac_WR,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underflow,
    input  logic                     clr_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DIV);

    localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]      LVL_HALF = (AW+1)'(DEPTH / 2);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CW-1:0]    CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] MIDSCALE = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    logic tick;
    logic push;
    logic pop;

    // Same inversion convention as the ADC capture path, so loopback is transparent.
    function automatic logic [WIDTH-1:0] to_dac(input logic [WIDTH-1:0] s);
        return (INVERT != 0) ? ~s : s;
    endfunction

    // Readiness looks only at the pre-pop level: a full FIFO never accepts.
    assign Din_ready = sys_RSTn && (level < LVL_FULL);
    assign push      = Din_valid && Din_ready;
    assign tick      = (state == RUN) && (cnt == CNT_MAX);
    assign pop       = tick && (level != '0);

    always_ff @(posedge sys_CLK) begin
        if (push) mem[wr_ptr] <= Din;
    end

    always_ff @(posedge sys_CLK) begin
        if (!sys_RSTn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge sys_CLK) begin
        if (!sys_RSTn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable) state <= PRIME;
                end
                PRIME: begin
                    cnt <= '0;
                    if (!enable)                state <= IDLE;
                    else if (level >= LVL_HALF) state <= RUN;
                end
                RUN: begin
                    // A tick in the cycle enable drops still fires; only the next cycle idles.
                    if (!enable) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= (cnt == CNT_MAX) ? '0 : cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_CLK) begin
        if (!sys_RSTn) begin
            Dout      <= to_dac(MIDSCALE);
            dac_WR    <= 1'b0;
            underflow <= 1'b0;
        end else begin
            dac_WR <= tick;
            if (pop) Dout <= to_dac(mem[rd_ptr]);
            // A new underflow event wins over a coincident clear.
            if (tick && level == '0) underflow <= 1'b1;
            else if (clr_underflow)  underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dac_feeder.sv
// Scoreboard bench for dac_feeder: expected DAC words are queued as samples
// are pushed and popped as each dac_WR strobe is observed.
module tb_dac_feeder;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [13:0] din;
    logic        din_valid;
    logic        din_ready;
    logic [13:0] dout;
    logic        dac_wr;
    logic [3:0]  level;
    logic        underflow;
    logic        clr;

    int n_cmp = 0;
    int n_err = 0;
    logic [13:0] exp_q[$];
    logic [13:0] last_exp;

    dac_feeder #(.WIDTH(14), .DEPTH(8), .DIV(4), .INVERT(1)) dut (
        .sys_CLK      (clk),
        .sys_RSTn     (rstn),
        .enable       (enable),
        .Din          (din),
        .Din_valid    (din_valid),
        .Din_ready    (din_ready),
        .Dout         (dout),
        .dac_WR       (dac_wr),
        .level        (level),
        .underflow    (underflow),
        .clr_underflow(clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    // Advance to the next negedge showing dac_WR; n = cycles taken, budget+1 on timeout.
    task automatic wait_wr(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dac_wr && n <= budget);
    endtask

    task automatic push_word(input logic [13:0] w);
        din = w;
        din_valid = 1'b1;
        exp_q.push_back(~w);
        step();
        din_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b1; din_valid = 1'b1; din = 14'h1234; clr = 1'b0;
        repeat (3) step();
        n_cmp++; if (dout !== 14'h1FFF) begin n_err++; $display("FAIL reset_dout got=%h want=1fff", dout); end
        n_cmp++; if (dac_wr !== 1'b0) begin n_err++; $display("FAIL reset_wr got=%b want=0", dac_wr); end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_level got=%0d want=0", level); end
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL reset_uf got=%b want=0", underflow); end
        n_cmp++; if (din_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b want=0", din_ready); end
        enable = 1'b0; din_valid = 1'b0; rstn = 1'b1;
        step();
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL reset_nopush got=%0d want=0", level); end
    endtask

    task automatic test_prime_stream();
        int n;
        logic [13:0] e;
        for (int i = 0; i < 4; i++) push_word(14'(i));
        n_cmp++; if (level !== 4'd4) begin n_err++; $display("FAIL prime_level got=%0d want=4", level); end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_wr(20, n);
            e = exp_q.pop_front();
            last_exp = e;
            n_cmp++; if (n !== ((i == 0) ? 6 : 4)) begin n_err++; $display("FAIL stream_gap%0d got=%0d want=%0d", i, n, (i == 0) ? 6 : 4); end
            n_cmp++; if (dout !== e) begin n_err++; $display("FAIL stream_dout%0d got=%h want=%h", i, dout, e); end
        end
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL stream_drained got=%0d want=0", level); end
    endtask

    task automatic test_underflow();
        int n;
        wait_wr(20, n);
        n_cmp++; if (n !== 4) begin n_err++; $display("FAIL uf_gap got=%0d want=4", n); end
        n_cmp++; if (dout !== last_exp) begin n_err++; $display("FAIL uf_hold got=%h want=%h", dout, last_exp); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_set got=%b want=1", underflow); end
        // Counter is now 0: clear well away from the next tick.
        clr = 1'b1; step(); clr = 1'b0;
        n_cmp++; if (underflow !== 1'b0) begin n_err++; $display("FAIL uf_clear got=%b want=0", underflow); end
        step(); step();
        clr = 1'b1; step(); clr = 1'b0;
        n_cmp++; if (dac_wr !== 1'b1) begin n_err++; $display("FAIL uf_tick2 got=%b want=1", dac_wr); end
        n_cmp++; if (underflow !== 1'b1) begin n_err++; $display("FAIL uf_setwins got=%b want=1", underflow); end
        enable = 1'b0; step();
        clr = 1'b1; step(); clr = 1'b0;
    endtask

    task automatic test_backpressure();
        din_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 14'h100 + 14'(i);
            n_cmp++; if (din_ready !== (i < 8)) begin n_err++; $display("FAIL bp_ready%0d got=%b want=%b", i, din_ready, (i < 8)); end
            if (i < 8) exp_q.push_back(~din);
            step();
        end
        din_valid = 1'b0;
        n_cmp++; if (level !== 4'd8) begin n_err++; $display("FAIL bp_level got=%0d want=8", level); end
    endtask

    task automatic test_enable_drop();
        int n;
        int pulses;
        logic [13:0] e;
        enable = 1'b1;
        wait_wr(20, n);
        e = exp_q.pop_front();
        n_cmp++; if (n !== 6) begin n_err++; $display("FAIL ed_first_gap got=%0d want=6", n); end
        n_cmp++; if (dout !== e) begin n_err++; $display("FAIL ed_first got=%h want=%h", dout, e); end
        step();
        enable = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin step(); if (dac_wr) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL ed_quiet got=%0d want=0", pulses); end
        n_cmp++; if (level !== 4'd7) begin n_err++; $display("FAIL ed_level got=%0d want=7", level); end
        n_cmp++; if (dout !== e) begin n_err++; $display("FAIL ed_hold got=%h want=%h", dout, e); end
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_wr(20, n);
            e = exp_q.pop_front();
            n_cmp++; if (n !== ((i == 0) ? 6 : 4)) begin n_err++; $display("FAIL ed_gap%0d got=%0d want=%0d", i, n, (i == 0) ? 6 : 4); end
            n_cmp++; if (dout !== e) begin n_err++; $display("FAIL ed_dout%0d got=%h want=%h", i, dout, e); end
        end
        n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL ed_level_end got=%0d want=3", level); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int n;
        logic [13:0] e;
        // Each pass starts one cycle after a tick; the third step lands in the next tick cycle.
        for (int k = 0; k < 2; k++) begin
            step(); step(); step();
            push_word(14'h200 + 14'(k));
            e = exp_q.pop_front();
            n_cmp++; if (dac_wr !== 1'b1) begin n_err++; $display("FAIL b2b_wr%0d got=%b want=1", k, dac_wr); end
            n_cmp++; if (dout !== e) begin n_err++; $display("FAIL b2b_dout%0d got=%h want=%h", k, dout, e); end
            n_cmp++; if (level !== 4'd3) begin n_err++; $display("FAIL b2b_level%0d got=%0d want=3", k, level); end
        end
        step();
        rstn = 1'b0; step(); rstn = 1'b1;
        exp_q.delete();
        n_cmp++; if (level !== 4'd0) begin n_err++; $display("FAIL mr_level got=%0d want=0", level); end
        n_cmp++; if (dout !== 14'h1FFF) begin n_err++; $display("FAIL mr_dout got=%h want=1fff", dout); end
        n_cmp++; if (dac_wr !== 1'b0) begin n_err++; $display("FAIL mr_wr got=%b want=0", dac_wr); end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin step(); if (dac_wr) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mr_quiet got=%0d want=0", pulses); end
        for (int i = 0; i < 4; i++) push_word(14'h300 + 14'(i));
        for (int i = 0; i < 2; i++) begin
            wait_wr(20, n);
            e = exp_q.pop_front();
            n_cmp++; if (n > 20) begin n_err++; $display("FAIL mr_timeout%0d got=%0d want<=20", i, n); end
            n_cmp++; if (dout !== e) begin n_err++; $display("FAIL mr_dout%0d got=%h want=%h", i, dout, e); end
        end
        enable = 1'b0;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_prime_stream();
        test_underflow();
        test_backpressure();
        test_enable_drop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
